milano_id_stage: RTL and testbench

Instruction-decode stage of the milano core, between the fetch stage and the ALU/execute stage. It takes one fetched instruction and its PC per handshake, decodes the RV32I opcode into an `alu_opt_e` operation, reads the register file and builds the immediate. The decoded operands and control go into a single registered pipeline slot. Valid/ready handshakes on both sides give back-pressure, and a flush input kills the slot on redirects.

---
 rtl/milano_pkg.sv | 73 +++++++
 rtl/milano_decoder.sv | 108 ++++++++++
 rtl/milano_id_stage.sv | 130 +++++++++++++
 tb/tb_milano_id_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/milano_pkg.sv
// Shared types for the milano core decode path: opcodes, ALU operations,
// operand/immediate selects and the decoder control bundle.
package milano_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OPCODE_DEFAULT  = 7'h00,
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0f,
        OPCODE_OP_IMM   = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_OP       = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6f,
        OPCODE_SYSTEM   = 7'h73
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_opt_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    typedef enum logic [1:0] {
        OPA_ZERO, OPA_RS1, OPA_PC
    } op_a_sel_e;

    // Immediate shifts feed only the 5-bit shamt, not the full I-immediate.
    typedef enum logic [1:0] {
        OPB_IMM, OPB_RS2, OPB_FOUR, OPB_SHAMT
    } op_b_sel_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_opt_e  alu_op;
        op_a_sel_e a_sel;
        op_b_sel_e b_sel;
        imm_sel_e  imm_sel;
        logic      rd_we;
        logic      illegal;
        opcode_e   opcode;
    } decode_ctrl_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_e sel);
        case (sel)
            IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   gen_imm = {instr[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: gen_imm = '0;
        endcase
    endfunction

endpackage

// File: rtl/milano_decoder.sv
// Combinational RV32I decoder: instruction word to ALU op, operand selects,
// immediate type, writeback enable and illegal flag.
module milano_decoder
    import milano_pkg::*;
(
    input  logic [31:0]  instr_i,
    output decode_ctrl_t ctrl_o
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        ctrl_o = '{alu_op: ALU_NONE, a_sel: OPA_ZERO, b_sel: OPB_IMM, imm_sel: IMM_NONE,
                   rd_we: 1'b0, illegal: 1'b0, opcode: OPCODE_DEFAULT};
        case (instr_i[6:0])
            OPCODE_LUI, OPCODE_AUIPC: begin
                ctrl_o.opcode  = opcode_e'(instr_i[6:0]);
                ctrl_o.alu_op  = ALU_ADD;
                ctrl_o.a_sel   = (instr_i[6:0] == OPCODE_AUIPC) ? OPA_PC : OPA_ZERO;
                ctrl_o.imm_sel = IMM_U;
                ctrl_o.rd_we   = 1'b1;
            end
            OPCODE_OP_IMM: begin
                ctrl_o.opcode  = OPCODE_OP_IMM;
                ctrl_o.a_sel   = OPA_RS1;
                ctrl_o.imm_sel = IMM_I;
                ctrl_o.rd_we   = 1'b1;
                case (funct3)
                    F3_ADD_SUB: ctrl_o.alu_op = ALU_ADD;
                    F3_SLT:     ctrl_o.alu_op = ALU_SLT;
                    F3_SLTU:    ctrl_o.alu_op = ALU_SLTU;
                    F3_XOR:     ctrl_o.alu_op = ALU_XOR;
                    F3_OR:      ctrl_o.alu_op = ALU_OR;
                    F3_AND:     ctrl_o.alu_op = ALU_AND;
                    F3_SLL:     ctrl_o.alu_op = ALU_SLL;
                    default:    ctrl_o.alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
                endcase
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    ctrl_o.b_sel   = OPB_SHAMT;
                    ctrl_o.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                end
            end
            OPCODE_OP: begin
                ctrl_o.opcode = OPCODE_OP;
                ctrl_o.a_sel  = OPA_RS1;
                ctrl_o.b_sel  = OPB_RS2;
                ctrl_o.rd_we  = 1'b1;
                case (funct3)
                    F3_ADD_SUB: ctrl_o.alu_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     ctrl_o.alu_op = ALU_SLL;
                    F3_SLT:     ctrl_o.alu_op = ALU_SLT;
                    F3_SLTU:    ctrl_o.alu_op = ALU_SLTU;
                    F3_XOR:     ctrl_o.alu_op = ALU_XOR;
                    F3_SRL_SRA: ctrl_o.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    F3_OR:      ctrl_o.alu_op = ALU_OR;
                    default:    ctrl_o.alu_op = ALU_AND;
                endcase
                ctrl_o.illegal = !((funct7 == F7_ZERO) ||
                                   ((funct7 == F7_ALT) &&
                                    (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
            end
            OPCODE_LOAD, OPCODE_STORE: begin
                ctrl_o.opcode  = opcode_e'(instr_i[6:0]);
                ctrl_o.alu_op  = ALU_ADD;
                ctrl_o.a_sel   = OPA_RS1;
                ctrl_o.imm_sel = (instr_i[6:0] == OPCODE_STORE) ? IMM_S : IMM_I;
                ctrl_o.rd_we   = (instr_i[6:0] == OPCODE_LOAD);
            end
            OPCODE_BRANCH: begin
                ctrl_o.opcode  = OPCODE_BRANCH;
                ctrl_o.a_sel   = OPA_RS1;
                ctrl_o.b_sel   = OPB_RS2;
                ctrl_o.imm_sel = IMM_B;
                ctrl_o.alu_op  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                ctrl_o.illegal = (funct3[2:1] == 2'b01);
            end
            OPCODE_JAL, OPCODE_JALR: begin
                ctrl_o.opcode  = opcode_e'(instr_i[6:0]);
                ctrl_o.alu_op  = ALU_ADD;
                ctrl_o.a_sel   = OPA_PC;
                ctrl_o.b_sel   = OPB_FOUR;
                ctrl_o.imm_sel = (instr_i[6:0] == OPCODE_JAL) ? IMM_J : IMM_I;
                ctrl_o.rd_we   = 1'b1;
            end
            OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
                ctrl_o.opcode = opcode_e'(instr_i[6:0]);
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
        if (ctrl_o.illegal) begin
            ctrl_o.alu_op  = ALU_NONE;
            ctrl_o.a_sel   = OPA_ZERO;
            ctrl_o.b_sel   = OPB_IMM;
            ctrl_o.imm_sel = IMM_NONE;
            ctrl_o.rd_we   = 1'b0;
        end
        if (instr_i[11:7] == 5'd0) begin
            ctrl_o.rd_we = 1'b0;
        end
    end

endmodule

// File: rtl/milano_id_stage.sv
// Instruction-decode stage: decodes one instruction per handshake, muxes the
// ALU operands and holds the result in a single valid/ready pipeline slot.
module milano_id_stage
    import milano_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            if_valid_i,
    output logic            id_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            id_valid_o,
    input  logic            ex_ready_i,
    output alu_opt_e        alu_op_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output opcode_e         opcode_o,
    output logic [2:0]      funct3_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            illegal_o
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        opcode_e         opcode;
        logic [2:0]      funct3;
        alu_opt_e        alu_op;
        logic [XLEN-1:0] alu_a;
        logic [XLEN-1:0] alu_b;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd_addr;
        logic            rd_we;
        logic            illegal;
    } slot_t;

    localparam slot_t SLOT_RESET = '{pc: '0, opcode: OPCODE_DEFAULT, funct3: '0,
                                     alu_op: ALU_NONE, alu_a: '0, alu_b: '0, imm: '0,
                                     rd_addr: '0, rd_we: 1'b0, illegal: 1'b0};

    decode_ctrl_t    ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            accept;
    logic            valid_d, valid_q;
    slot_t           slot_d, slot_q;

    milano_decoder u_decoder (
        .instr_i (instr_i),
        .ctrl_o  (ctrl)
    );

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign id_ready_o = !valid_q || ex_ready_i;
    assign accept     = if_valid_i && id_ready_o && !flush_i;

    always_comb begin
        imm  = gen_imm(instr_i, ctrl.imm_sel);
        op_a = '0;
        op_b = '0;
        case (ctrl.a_sel)
            OPA_RS1: op_a = rs1_data_i;
            OPA_PC:  op_a = pc_i;
            default: op_a = '0;
        endcase
        case (ctrl.b_sel)
            OPB_RS2:   op_b = rs2_data_i;
            OPB_FOUR:  op_b = XLEN'(4);
            OPB_SHAMT: op_b = XLEN'(instr_i[24:20]);
            default:   op_b = imm;
        endcase
    end

    // Flush beats accept; an empty or drained slot drops valid.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d        = 1'b1;
            slot_d.pc      = pc_i;
            slot_d.opcode  = ctrl.opcode;
            slot_d.funct3  = instr_i[14:12];
            slot_d.alu_op  = ctrl.alu_op;
            slot_d.alu_a   = op_a;
            slot_d.alu_b   = op_b;
            slot_d.imm     = imm;
            slot_d.rd_addr = instr_i[11:7];
            slot_d.rd_we   = ctrl.rd_we;
            slot_d.illegal = ctrl.illegal;
        end else if (ex_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            slot_q  <= SLOT_RESET;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign id_valid_o = valid_q;
    assign alu_op_o   = slot_q.alu_op;
    assign alu_a_o    = slot_q.alu_a;
    assign alu_b_o    = slot_q.alu_b;
    assign imm_o      = slot_q.imm;
    assign pc_o       = slot_q.pc;
    assign opcode_o   = slot_q.opcode;
    assign funct3_o   = slot_q.funct3;
    assign rd_addr_o  = slot_q.rd_addr;
    assign rd_we_o    = slot_q.rd_we;
    assign illegal_o  = slot_q.illegal;

endmodule

// File: tb/tb_milano_id_stage.sv
// Self-checking bench for milano_id_stage: directed decode/handshake steps
// followed by randomized traffic against a behavioural slot model.
module tb_milano_id_stage;
    import milano_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_valid_i, id_ready_o, flush_i, id_valid_o, ex_ready_i;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    alu_opt_e    alu_op_o;
    logic [31:0] alu_a_o, alu_b_o, imm_o, pc_o;
    opcode_e     opcode_o;
    logic [2:0]  funct3_o;
    logic        rd_we_o, illegal_o;

    always #5 clk_i = ~clk_i;

    milano_id_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .if_valid_i(if_valid_i), .id_ready_o(id_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i), .alu_op_o(alu_op_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .imm_o(imm_o), .pc_o(pc_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .rd_addr_o(rd_addr_o),
        .rd_we_o(rd_we_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [31:0] pc;
        opcode_e     opc;
        logic [2:0]  f3;
        alu_opt_e    op;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic        we, ill;
        bit          chk_ops, chk_imm;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] regs [32];
    bit          mvalid;
    exp_t        mslot;
    logic [31:0] delivered [$];

    assign rs1_data_i = regs[instr_i[19:15]];
    assign rs2_data_i = regs[instr_i[24:20]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        alu_opt_e    f3_ops [8];
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        iimm = 32'($signed(ins) >>> 20);
        simm = (iimm & ~32'h1f) | 32'(ins[11:7]);
        bimm = (ins[31] ? 32'hFFFFF000 : 32'h0) | (32'(ins[7]) << 11) |
               (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        uimm = ins & 32'hFFFFF000;
        jimm = (ins[31] ? 32'hFFF00000 : 32'h0) | (32'(ins[19:12]) << 12) |
               (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        f3_ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        e.pc = pc; e.f3 = f3; e.rd = ins[11:7]; e.opc = OPCODE_DEFAULT; e.op = ALU_NONE;
        e.a = 0; e.b = 0; e.imm = 0; e.we = 0; e.ill = 0; e.chk_ops = 1; e.chk_imm = 1;
        case (opc)
            7'h37: begin e.opc = OPCODE_LUI;   e.op = ALU_ADD; e.a = 0;  e.b = uimm; e.imm = uimm; e.we = 1; end
            7'h17: begin e.opc = OPCODE_AUIPC; e.op = ALU_ADD; e.a = pc; e.b = uimm; e.imm = uimm; e.we = 1; end
            7'h13: begin
                e.opc = OPCODE_OP_IMM; e.a = r1; e.b = iimm; e.imm = iimm; e.we = 1; e.op = f3_ops[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = 32'(ins[24:20]);
                    if (f7 != 7'h00 && f7 != 7'h20) e.ill = 1;
                    if (f3 == 3'd5 && ins[30]) e.op = ALU_SRA;
                end
            end
            7'h33: begin
                e.opc = OPCODE_OP; e.a = r1; e.b = r2; e.we = 1; e.chk_imm = 0; e.op = f3_ops[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
                else if (f7 != 7'h00) e.ill = 1;
            end
            7'h03: begin e.opc = OPCODE_LOAD;  e.op = ALU_ADD; e.a = r1; e.b = iimm; e.imm = iimm; e.we = 1; end
            7'h23: begin e.opc = OPCODE_STORE; e.op = ALU_ADD; e.a = r1; e.b = simm; e.imm = simm; e.we = 0; end
            7'h63: begin
                e.opc = OPCODE_BRANCH; e.a = r1; e.b = r2; e.imm = bimm; e.we = 0;
                e.op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
            end
            7'h6f: begin e.opc = OPCODE_JAL;  e.op = ALU_ADD; e.a = pc; e.b = 4; e.imm = jimm; e.we = 1; end
            7'h67: begin e.opc = OPCODE_JALR; e.op = ALU_ADD; e.a = pc; e.b = 4; e.imm = iimm; e.we = 1; end
            7'h0f, 7'h73: begin e.opc = opcode_e'(opc); e.chk_ops = 0; e.chk_imm = 0; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.op = ALU_NONE; e.we = 0; e.chk_ops = 0; e.chk_imm = 0; end
        if (e.rd == 5'd0) e.we = 0;
        return e;
    endfunction

    function automatic logic [31:0] gen_rand();
        logic [6:0]  opcs [11];
        logic [31:0] r;
        int          sel;
        opcs = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h0f, 7'h73};
        r    = $urandom;
        sel  = $urandom_range(0, 11);
        if (sel < 11) r[6:0] = opcs[sel];
        if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
            r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic exr);
        if_valid_i = v; instr_i = ins; pc_i = pc; flush_i = fl; ex_ready_i = exr;
    endtask

    task automatic check_slot();
        chk("id_valid", id_valid_o, mvalid);
        if (mvalid) begin
            chk("pc", pc_o, mslot.pc);
            chk("opcode", 32'(opcode_o), 32'(mslot.opc));
            chk("funct3", funct3_o, mslot.f3);
            chk("alu_op", 32'(alu_op_o), 32'(mslot.op));
            chk("rd_addr", rd_addr_o, mslot.rd);
            chk("rd_we", rd_we_o, mslot.we);
            chk("illegal", illegal_o, mslot.ill);
            if (mslot.chk_ops) begin
                chk("alu_a", alu_a_o, mslot.a);
                chk("alu_b", alu_b_o, mslot.b);
            end
            if (mslot.chk_imm) chk("imm", imm_o, mslot.imm);
        end
    endtask

    // One clock: check combinational outputs, advance the model at the edge, check the slot.
    task automatic cycle();
        bit   exp_acc;
        exp_t nxt;
        #1;
        chk("id_ready", id_ready_o, !mvalid || ex_ready_i);
        chk("rs1_addr", rs1_addr_o, instr_i[19:15]);
        chk("rs2_addr", rs2_addr_o, instr_i[24:20]);
        exp_acc = if_valid_i && (!mvalid || ex_ready_i) && !flush_i;
        nxt     = ref_decode(instr_i, pc_i, regs[instr_i[19:15]], regs[instr_i[24:20]]);
        if (id_valid_o && ex_ready_i) delivered.push_back(pc_o);
        @(posedge clk_i);
        #1;
        if (flush_i) mvalid = 0;
        else if (exp_acc) begin mvalid = 1; mslot = nxt; end
        else if (ex_ready_i) mvalid = 0;
        check_slot();
    endtask

    initial begin
        logic [31:0] stream [4];
        logic [31:0] exp_pcs [5];
        int          k;
        bit          acc;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 0; regs[1] = 10; regs[2] = 3;
        mvalid = 0;
        rst_ni = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 1);
        #12;
        chk("rst_valid", id_valid_o, 1'b0);
        chk("rst_ready", id_ready_o, 1'b1);
        chk("rst_alu_op", 32'(alu_op_o), 32'(ALU_NONE));
        chk("rst_opcode", 32'(opcode_o), 32'(OPCODE_DEFAULT));
        chk("rst_a", alu_a_o, 32'h0);
        chk("rst_imm", imm_o, 32'h0);
        chk("rst_we", rd_we_o, 1'b0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        drive(1, 32'h00500093, 32'h0, 0, 1); cycle();
        chk("addi_op", 32'(alu_op_o), 32'(ALU_ADD));
        chk("addi_a", alu_a_o, 32'd0);
        chk("addi_b", alu_b_o, 32'd5);
        chk("addi_rd", rd_addr_o, 5'd1);
        chk("addi_we", rd_we_o, 1'b1);
        chk("addi_ill", illegal_o, 1'b0);

        drive(1, 32'h402081b3, 32'h4, 0, 1); cycle();
        chk("sub_op", 32'(alu_op_o), 32'(ALU_SUB));
        chk("sub_a", alu_a_o, 32'd10);
        chk("sub_b", alu_b_o, 32'd3);
        chk("sub_rd", rd_addr_o, 5'd3);

        drive(1, 32'h4030d093, 32'h8, 0, 1); cycle();
        chk("srai_op", 32'(alu_op_o), 32'(ALU_SRA));
        chk("srai_b", alu_b_o, 32'd3);

        drive(1, 32'h123452b7, 32'hC, 0, 1); cycle();
        chk("lui_a", alu_a_o, 32'h0);
        chk("lui_b", alu_b_o, 32'h12345000);

        drive(1, 32'h00001317, 32'h100, 0, 1); cycle();
        chk("auipc_a", alu_a_o, 32'h100);
        chk("auipc_b", alu_b_o, 32'h1000);

        // Back-pressure: three stalled cycles, then release and drain.
        stream  = '{32'h00100113, 32'h00208193, 32'h00310233, 32'h0040a2a3};
        exp_pcs = '{32'h100, 32'h200, 32'h204, 32'h208, 32'h20C};
        delivered.delete();
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            drive(1, stream[k], 32'h200 + 32'(4 * k), 0, (c >= 3));
            acc = !mvalid || (c >= 3);
            cycle();
            if (c < 3) chk("stall_ready", id_ready_o, 1'b0);
            if (acc) k++;
        end
        chk("stream_accepted", 32'(k), 32'd4);
        drive(0, 32'h0, 32'h0, 0, 1); cycle(); cycle();
        chk("deliv_count", 32'(delivered.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("deliv_%0d", i), (i < delivered.size()) ? delivered[i] : 32'hDEADBEEF, exp_pcs[i]);

        // Flush with an incoming instruction while the slot is full.
        drive(1, 32'h00500093, 32'h300, 0, 0); cycle();
        delivered.delete();
        drive(1, 32'h00700093, 32'h304, 1, 0); cycle();
        chk("flush_valid", id_valid_o, 1'b0);
        drive(0, 32'h0, 32'h0, 0, 1); cycle(); cycle();
        chk("flush_drop", 32'(delivered.size()), 32'd0);

        drive(1, 32'hFFFFFFFF, 32'h400, 0, 1); cycle();
        chk("ill_flag", illegal_o, 1'b1);
        chk("ill_op", 32'(alu_op_o), 32'(ALU_NONE));
        chk("ill_we", rd_we_o, 1'b0);
        drive(1, 32'h00000463, 32'h404, 0, 1); cycle();
        chk("beq_op", 32'(alu_op_o), 32'(ALU_SUB));
        chk("beq_imm", imm_o, 32'd8);
        chk("beq_we", rd_we_o, 1'b0);

        // Asynchronous reset while the slot is occupied.
        drive(1, 32'h00500093, 32'h500, 0, 0); cycle();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", id_valid_o, 1'b0);
        chk("arst_op", 32'(alu_op_o), 32'(ALU_NONE));
        chk("arst_pc", pc_o, 32'h0);
        mvalid = 0;
        drive(0, 32'h0, 32'h0, 0, 1);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, gen_rand(), $urandom & 32'hFFFFFFFC,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
